// File: rtl/fp_inflight_cam.sv
// fp_inflight_cam: tag-indexed tracker for in-flight FP operations.
// Holds rd/op/writeback-enable per outstanding op, answers RAW busy
// lookups for three sources, squashes older WAW results and returns the
// entry contents when the FPU hands back a tag.
module fp_inflight_cam #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2,
    parameter int OP_W  = 3,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_l,
    // allocation from decode
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    input  logic [OP_W-1:0]  alloc_op,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    // RAW busy lookup
    input  logic [4:0]       src_rs1,
    input  logic [4:0]       src_rs2,
    input  logic [4:0]       src_rs3,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             rs3_busy,
    // completion from the FPU
    input  logic             cmpl_valid,
    input  logic [TAG_W-1:0] cmpl_tag,
    output logic [4:0]       cmpl_rd,
    output logic [OP_W-1:0]  cmpl_op,
    output logic             cmpl_wb,
    output logic             cmpl_err,
    // bookkeeping
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] wb_q;
    logic [4:0]       rd_q [DEPTH];
    logic [OP_W-1:0]  op_q [DEPTH];

    logic             any_free;
    logic [TAG_W-1:0] free_tag;
    logic             alloc_fire;
    logic             cmpl_fire;

    // Lowest-index free entry: scanning downwards lets the lowest free index win.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        any_free = 1'b0;
        free_tag = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                any_free = 1'b1;
                free_tag = TAG_W'(i);
            end
        end
    end

    assign alloc_ready = ~flush & any_free;
    assign alloc_tag   = free_tag;
    assign alloc_fire  = alloc_valid & alloc_ready;

    // Completion read port: purely combinational view of entry[cmpl_tag].
    assign cmpl_rd   = rd_q[cmpl_tag];
    assign cmpl_op   = op_q[cmpl_tag];
    assign cmpl_wb   = cmpl_valid & valid_q[cmpl_tag] & wb_q[cmpl_tag];
    assign cmpl_err  = cmpl_valid & ~valid_q[cmpl_tag];
    assign cmpl_fire = cmpl_valid & valid_q[cmpl_tag];

    // RAW busy: any valid entry targeting the source register; wb is ignored.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        rs3_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && rd_q[i] == src_rs1) rs1_busy = 1'b1;
            if (valid_q[i] && rd_q[i] == src_rs2) rs2_busy = 1'b1;
            if (valid_q[i] && rd_q[i] == src_rs3) rs3_busy = 1'b1;
        end
    end

    // Occupancy count from the registered valid bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(valid_q[i]);
        end
    end

    assign empty = (count == '0);

    // Entry state update: flush wins; otherwise completion, WAW squash and
    // allocation all land on the same edge. The allocated entry is always a
    // free one, so it never collides with the entry being completed.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            // NOTE: rd/op storage is reset along with the valid bits so that the completion read port shows zeros after reset.
            valid_q <= '0;
            wb_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
                op_q[i] <= '0;
            end
        end else if (flush) begin
            // NOTE: non-blocking assignments keep every entry update reading pre-edge state.
            valid_q <= '0;
            wb_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cmpl_fire && cmpl_tag == TAG_W'(i)) begin
                    valid_q[i] <= 1'b0;
                end
                if (alloc_fire && alloc_tag != TAG_W'(i) && valid_q[i] && rd_q[i] == alloc_rd) begin
                    wb_q[i] <= 1'b0;
                end
                if (alloc_fire && alloc_tag == TAG_W'(i)) begin
                    valid_q[i] <= 1'b1;
                    wb_q[i]    <= 1'b1;
                    rd_q[i]    <= alloc_rd;
                    op_q[i]    <= alloc_op;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_inflight_cam.sv
// Scoreboard bench for fp_inflight_cam: stimulus drives one cycle at a time
// just after the rising edge and queues the expected outputs for that cycle;
// the monitor drains the queue on the falling edge and compares.
module tb_fp_inflight_cam;

    localparam int DEPTH = 4;
    localparam int TAG_W = 2;
    localparam int OP_W  = 3;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_l;
    logic             alloc_valid;
    logic [4:0]       alloc_rd;
    logic [OP_W-1:0]  alloc_op;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic [4:0]       src_rs1, src_rs2, src_rs3;
    logic             rs1_busy, rs2_busy, rs3_busy;
    logic             cmpl_valid;
    logic [TAG_W-1:0] cmpl_tag;
    logic [4:0]       cmpl_rd;
    logic [OP_W-1:0]  cmpl_op;
    logic             cmpl_wb;
    logic             cmpl_err;
    logic             flush;
    logic [CNT_W-1:0] count;
    logic             empty;

    fp_inflight_cam #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_l(rst_l),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_op(alloc_op),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .src_rs1(src_rs1), .src_rs2(src_rs2), .src_rs3(src_rs3),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs3_busy(rs3_busy),
        .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag),
        .cmpl_rd(cmpl_rd), .cmpl_op(cmpl_op), .cmpl_wb(cmpl_wb), .cmpl_err(cmpl_err),
        .flush(flush), .count(count), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        S_READY, S_TAG, S_BUSY1, S_BUSY2, S_BUSY3,
        S_CRD, S_COP, S_CWB, S_CERR, S_COUNT, S_EMPTY
    } sig_e;

    typedef struct {
        sig_e  sig;
        int    exp;
        string name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic int get_val(sig_e s);
        case (s)
            S_READY: return int'(alloc_ready);
            S_TAG:   return int'(alloc_tag);
            S_BUSY1: return int'(rs1_busy);
            S_BUSY2: return int'(rs2_busy);
            S_BUSY3: return int'(rs3_busy);
            S_CRD:   return int'(cmpl_rd);
            S_COP:   return int'(cmpl_op);
            S_CWB:   return int'(cmpl_wb);
            S_CERR:  return int'(cmpl_err);
            S_COUNT: return int'(count);
            S_EMPTY: return int'(empty);
            default: return -1;
        endcase
    endfunction

    task automatic check(input sig_e s, input int exp, input string name);
        exp_t e;
        e.sig  = s;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare every queued expectation on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t e;
                int   act;
                e   = sb.pop_front();
                act = get_val(e.sig);
                n_tests++;
                if (act != e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %0d expected %0d at %0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        cmpl_valid  = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic [OP_W-1:0] op);
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        alloc_op    = op;
    endtask

    task automatic do_cmpl(input logic [TAG_W-1:0] tag);
        cmpl_valid = 1'b1;
        cmpl_tag   = tag;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        rst_l = 1'b0;
        alloc_valid = 1'b0; alloc_rd = '0; alloc_op = '0;
        src_rs1 = '0; src_rs2 = '0; src_rs3 = '0;
        cmpl_valid = 1'b0; cmpl_tag = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_l = 1'b1;

        // Post-reset state, with a completion to an invalid entry.
        do_cmpl(0);
        check(S_COUNT, 0, "rst_count"); check(S_EMPTY, 1, "rst_empty");
        check(S_READY, 1, "rst_ready"); check(S_TAG, 0, "rst_tag");
        check(S_BUSY1, 0, "rst_busy1"); check(S_CERR, 1, "rst_err");
        check(S_CWB, 0, "rst_wb"); check(S_CRD, 0, "rst_crd"); check(S_COP, 0, "rst_cop");

        // Two back-to-back allocs, busy visible one cycle later.
        tick(); do_alloc(3, 2); src_rs1 = 7; src_rs2 = 3;
        check(S_COUNT, 0, "a1_count"); check(S_READY, 1, "a1_ready"); check(S_TAG, 0, "a1_tag");
        check(S_BUSY1, 0, "a1_busy1");
        tick(); do_alloc(7, 3);
        check(S_TAG, 1, "a2_tag"); check(S_COUNT, 1, "a2_count");
        check(S_BUSY1, 0, "a2_busy1_not_yet"); check(S_BUSY2, 1, "a2_busy2");
        tick();
        check(S_COUNT, 2, "a3_count"); check(S_BUSY1, 1, "a3_busy1");

        // Drain both entries.
        tick(); do_cmpl(0);
        check(S_CRD, 3, "c0_rd"); check(S_COP, 2, "c0_op"); check(S_CWB, 1, "c0_wb"); check(S_CERR, 0, "c0_err");
        tick(); do_cmpl(1);
        check(S_CRD, 7, "c1_rd"); check(S_COP, 3, "c1_op"); check(S_CWB, 1, "c1_wb");
        tick();
        check(S_COUNT, 0, "drain_count"); check(S_EMPTY, 1, "drain_empty"); check(S_BUSY1, 0, "drain_busy1");

        // Fill with rd 1..4.
        tick(); do_alloc(1, 0); check(S_TAG, 0, "f0_tag");
        tick(); do_alloc(2, 1); check(S_TAG, 1, "f1_tag");
        tick(); do_alloc(3, 4); check(S_TAG, 2, "f2_tag");
        tick(); do_alloc(4, 5); check(S_TAG, 3, "f3_tag");
        tick(); do_alloc(9, 1); src_rs1 = 3; src_rs2 = 9;
        check(S_READY, 0, "full_ready"); check(S_COUNT, 4, "full_count"); check(S_BUSY1, 1, "full_busy1");
        tick(); do_alloc(9, 1); do_cmpl(2);
        check(S_READY, 0, "full_c2_ready"); check(S_CRD, 3, "full_c2_rd");
        check(S_COP, 4, "full_c2_op"); check(S_CWB, 1, "full_c2_wb"); check(S_BUSY1, 1, "full_c2_busy1");
        tick();
        check(S_READY, 1, "freed_ready"); check(S_TAG, 2, "freed_tag"); check(S_COUNT, 3, "freed_count");
        check(S_BUSY1, 0, "freed_busy1_drop"); check(S_BUSY2, 0, "ignored_alloc_busy2");

        // Refill, then alloc and completion of tag 3 in the same full cycle.
        tick(); do_alloc(10, 1); check(S_TAG, 2, "refill_tag");
        tick(); do_alloc(11, 2); do_cmpl(3); src_rs3 = 11;
        check(S_READY, 0, "sim_ready"); check(S_COUNT, 4, "sim_count");
        check(S_CRD, 4, "sim_crd"); check(S_COP, 5, "sim_cop"); check(S_CWB, 1, "sim_cwb");
        tick();
        check(S_TAG, 3, "sim_next_tag"); check(S_COUNT, 3, "sim_next_count");
        check(S_READY, 1, "sim_next_ready"); check(S_BUSY3, 0, "sim_dropped_busy3");

        // Free tags 0 and 1, then WAW on rd 5.
        tick(); do_cmpl(0); check(S_CRD, 1, "w_c0_rd");
        tick(); do_cmpl(1); check(S_CRD, 2, "w_c1_rd");
        tick(); do_alloc(5, 0); src_rs1 = 5;
        check(S_COUNT, 1, "waw_start_count"); check(S_TAG, 0, "waw_a0_tag");
        tick(); do_alloc(5, 2);
        check(S_TAG, 1, "waw_a1_tag"); check(S_BUSY1, 1, "waw_busy1");
        tick(); do_cmpl(0);
        check(S_CRD, 5, "waw_c0_rd"); check(S_CWB, 0, "waw_c0_wb_squashed"); check(S_COUNT, 3, "waw_count");
        tick(); do_cmpl(1);
        check(S_CRD, 5, "waw_c1_rd"); check(S_COP, 2, "waw_c1_op"); check(S_CWB, 1, "waw_c1_wb");
        check(S_BUSY1, 1, "waw_c1_busy1");
        tick();
        check(S_BUSY1, 0, "waw_busy1_drop"); check(S_COUNT, 1, "waw_end_count");

        // Alloc rd 10 while completing the older rd 10 entry (tag 2).
        tick(); do_alloc(10, 3); do_cmpl(2); src_rs1 = 10;
        check(S_TAG, 0, "same_rd_tag"); check(S_CRD, 10, "same_rd_crd"); check(S_CWB, 1, "same_rd_cwb");
        tick();
        check(S_COUNT, 1, "same_rd_count"); check(S_BUSY1, 1, "same_rd_busy1");
        tick(); do_cmpl(0);
        check(S_CWB, 1, "same_rd_new_wb"); check(S_COP, 3, "same_rd_new_op");
        tick();
        check(S_COUNT, 0, "same_rd_end_count");

        // Erroring completion to an invalid entry.
        tick(); do_alloc(20, 1);
        tick(); do_cmpl(1);
        check(S_CERR, 1, "err_flag"); check(S_CWB, 0, "err_wb"); check(S_COUNT, 1, "err_count");
        tick();
        check(S_COUNT, 1, "err_count_after"); check(S_CERR, 0, "err_idle");

        // Flush with concurrent alloc and completion.
        tick(); do_alloc(21, 0); check(S_TAG, 1, "fl_a1_tag");
        tick(); do_alloc(22, 0); check(S_TAG, 2, "fl_a2_tag");
        tick(); flush = 1'b1; do_alloc(23, 1); do_cmpl(1);
        src_rs1 = 20; src_rs2 = 21; src_rs3 = 23;
        check(S_COUNT, 3, "fl_count"); check(S_READY, 0, "fl_ready");
        check(S_CRD, 21, "fl_crd"); check(S_CWB, 1, "fl_cwb");
        tick();
        check(S_COUNT, 0, "fl_after_count"); check(S_EMPTY, 1, "fl_after_empty");
        check(S_BUSY1, 0, "fl_busy1"); check(S_BUSY2, 0, "fl_busy2"); check(S_BUSY3, 0, "fl_busy3");

        // Asynchronous reset mid-stream.
        tick(); do_alloc(6, 0); src_rs1 = 6;
        tick(); do_alloc(8, 1);
        tick();
        check(S_COUNT, 2, "pre_rst_count"); check(S_BUSY1, 1, "pre_rst_busy1");
        tick(); rst_l = 1'b0; do_cmpl(1);
        check(S_COUNT, 0, "arst_count"); check(S_EMPTY, 1, "arst_empty");
        check(S_BUSY1, 0, "arst_busy1"); check(S_TAG, 0, "arst_tag"); check(S_READY, 1, "arst_ready");
        check(S_CERR, 1, "arst_err"); check(S_CRD, 0, "arst_crd");
        tick(); rst_l = 1'b1;

        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_inflight_cam.md
# fp_inflight_cam

Parametrised in-flight tracker for floating-point operations between issue in decode and writeback from the FPU. Each allocated operation receives a tag. The block holds the destination register, operation class and a writeback-enable bit for every outstanding operation. Decode uses it for RAW busy checks on up to three sources, WAW squashing of older results, and tag-indexed completion lookup. It generalises the non-blocking-load CAM to configurable depth and FP op classes, and adds flush and count.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- TAG_W, 2, tag width; must equal log2(DEPTH)
- OP_W, 3, op-class width; encodings 0 add, 1 sub, 2 mul, 3 div, 4 sqrt, 5 fma, 6–7 reserved
- CNT_W, 3, count width; must equal log2(DEPTH+1) rounded up

- clk  in  1  core clock
- rst_l  in  1  asynchronous active-low reset
- alloc_valid  in  1  request to allocate an entry
- alloc_rd  in  5  destination FP register
- alloc_op  in  OP_W  op class
- alloc_ready  out  1  a free entry exists and flush is low
- alloc_tag  out  TAG_W  tag granted when alloc_valid & alloc_ready
- src_rs1 / src_rs2 / src_rs3  in  5 each  decode source registers
- rs1_busy / rs2_busy / rs3_busy  out  1 each  the source matches a valid entry's rd
- cmpl_valid  in  1  FPU result returning
- cmpl_tag  in  TAG_W  tag of the returning result
- cmpl_rd  out  5  rd of the entry at cmpl_tag
- cmpl_op  out  OP_W  op of the entry at cmpl_tag
- cmpl_wb  out  1  the result must be written to the register file
- cmpl_err  out  1  cmpl_valid to an invalid entry
- flush  in  1  discard all entries
- count  out  CNT_W  number of valid entries
- empty  out  1  count == 0

## Operation
- Per-entry state: valid, wb, rd[4:0], op[OP_W-1:0]. All state is flopped.
- Allocation
  - alloc_tag = lowest-index invalid entry (priority encoder).
  - alloc_ready = ~flush & any entry invalid.
  - On alloc_valid & alloc_ready, the entry is written next edge with valid=1, wb=1, rd, op.
  - alloc_valid while alloc_ready=0 is ignored; nothing is written.
- WAW squash: on an accepted alloc, every other valid entry whose rd == alloc_rd has wb cleared next edge. At most one entry per rd has wb=1.
- Busy lookup
  - rsN_busy = OR over valid entries of (rd == src_rsN). wb is not considered.
  - Reads registered state only; an alloc in the current cycle is not visible until the next cycle.
- Completion
  - cmpl_rd, cmpl_op and cmpl_wb are combinational reads of entry[cmpl_tag].
  - cmpl_wb = entry.wb & entry.valid & cmpl_valid.
  - cmpl_err = cmpl_valid & ~entry.valid. An erroring completion changes no state.
  - A valid completion clears the entry's valid bit next edge.
- Simultaneous alloc and completion in the same cycle
  - The completing entry is not reusable in that cycle; alloc_tag is based on registered valids.
  - Both updates apply at the same edge.
  - If the alloc rd equals the completing entry's rd, the wb clear is harmless because that entry is freed.
- Flush
  - All valid bits clear next edge.
  - alloc_ready is forced 0 during flush; a concurrent alloc is dropped.
  - A concurrent completion's outputs are still driven, but state ends empty.
- count = popcount(valid); empty = (count == 0).

## Timing
- Reset (rst_l low, asynchronous): all valid=0 and wb=0, rd and op zeroed.
  - Outputs after reset: count=0, empty=1, alloc_ready=1 (if flush=0), alloc_tag=0, rsN_busy=0, cmpl_err=cmpl_valid, cmpl_wb=0, cmpl_rd=0, cmpl_op=0.
- Reset asserted mid-operation discards all entries immediately, with no partial updates.
- Combinational paths:
  - alloc_ready and alloc_tag from state and flush.
  - busy outputs from state and sources.
  - cmpl_* from state and cmpl_tag/cmpl_valid.
- No combinational path from alloc_* to any output.
- Latency:
  - alloc to busy visible: 1 cycle.
  - Completion to entry free: 1 cycle.
  - Completion to busy drop: 1 cycle.
  - Flush to empty: 1 cycle.
- Throughput: one alloc and one completion per cycle.
- Full condition: alloc_ready=0 with count==DEPTH, stays so until a completion edge.

## Test plan
- Reset, then alloc rd=3 op=2, rd=7 op=3 on consecutive cycles -> alloc_tag 0 then 1; count=2; src_rs1=7 gives rs1_busy=1 one cycle after the second alloc.
- Fill DEPTH=4 (rd 1..4) -> alloc_ready=0 and count=4. Complete tag 2 -> next cycle alloc_ready=1, alloc_tag=2, rs1_busy for rd 3 drops.
- Alloc rd=5 (tag 0), then rd=5 again (tag 1). Complete tag 0 -> cmpl_wb=0, cmpl_rd=5. Complete tag 1 -> cmpl_wb=1.
- Full table, alloc_valid and cmpl_valid tag 3 in the same cycle -> alloc ignored that cycle; next cycle alloc_tag=3 and count=3.
- cmpl_valid with tag 1 while entry 1 is invalid -> cmpl_err=1, count unchanged.
- Three entries valid, flush together with alloc_valid -> alloc_ready=0 that cycle; next cycle count=0, empty=1, all busy=0. Assert rst_l low mid-stream -> same empty state immediately, without waiting for a clock edge.
